// File: rtl/spi_word_packer_pkg.sv
// Shared constants and types for the SPI byte/word packer.
// Chip-select polarity lives here so both the synchroniser and the top agree.
package spi_word_packer_pkg;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchroniser for the raw chip select, plus registered fall/rise strobes.
// All stages reset to the deselected level so reset never fakes a frame start.
module spi_cs_sync
    import spi_word_packer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic cs_fall,
    output logic cs_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_fall;
    logic r_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= CS_IDLE;
            r_sync2 <= CS_IDLE;
            r_sync3 <= CS_IDLE;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= cs;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_fall  <= (r_sync3 == CS_IDLE) && (r_sync2 == CS_ACTIVE);
            r_rise  <= (r_sync3 == CS_ACTIVE) && (r_sync2 == CS_IDLE);
        end
    end

    assign cs_fall = r_fall;
    assign cs_rise = r_rise;

endmodule

// File: rtl/spi_word_packer.sv
// Packs SPI bytes into words for the rx buffer and serialises tx buffer words into bytes.
// Handshake: spi_ready is a one-cycle byte strobe; tx_rd pops the send head in the cycle it is loaded.
module spi_word_packer
    import spi_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic                      spi_ready,
    input  logic [SPI_DATA_WIDTH-1:0] spi_data_receive,
    output logic [SPI_DATA_WIDTH-1:0] spi_data_send,
    input  logic                      tx_valid,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_rd,
    output logic                      rx_wr,
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic [CNT_WIDTH-1:0]      word_cnt,
    output logic                      frame_done,
    output logic                      frame_error,
    output logic                      tx_underflow,
    output logic                      dbg_state
);

    localparam int BYTES = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    logic                  w_cs_fall;
    logic                  w_cs_rise;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_byte;
    logic                  w_end;
    logic                  w_word_end;
    logic                  w_tx_load;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] w_rx_word;

    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_wr;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_frame_done;
    logic                  r_frame_error;
    logic                  r_tx_underflow;

    spi_cs_sync u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .cs_fall (w_cs_fall),
        .cs_rise (w_cs_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bytes are only accepted inside a frame; a byte coinciding with cs_rise is still taken.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_byte       = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                w_byte = spi_ready;
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_end        = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_word_end = w_byte && (r_idx == IDX_LAST);
    assign w_idx_next = w_word_end ? '0 : (w_byte ? r_idx + IDX_W'(1) : r_idx);
    assign w_rx_word  = {r_rx_shift[DATA_WIDTH-SPI_DATA_WIDTH-1:0], spi_data_receive};
    assign w_tx_load  = w_start || w_word_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx          <= '0;
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_rx_wr        <= 1'b0;
            r_tx_shift     <= '0;
            r_word_cnt     <= '0;
            r_frame_done   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_tx_underflow <= 1'b0;
        end else begin
            r_rx_wr      <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_idx          <= '0;
                r_word_cnt     <= '0;
                r_frame_error  <= 1'b0;
                r_tx_underflow <= 1'b0;
            end
            if (w_byte) begin
                r_idx      <= w_idx_next;
                r_rx_shift <= w_rx_word;
                r_tx_shift <= r_tx_shift << SPI_DATA_WIDTH;
                if (w_word_end) begin
                    r_rx_wr   <= 1'b1;
                    r_rx_data <= w_rx_word;
                    if (r_word_cnt != '1) begin
                        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            // An empty send buffer feeds zeros and latches underflow until the next frame.
            if (w_tx_load) begin
                r_tx_shift <= tx_valid ? tx_data : '0;
                if (!tx_valid) begin
                    r_tx_underflow <= 1'b1;
                end
            end
            if (w_end) begin
                r_frame_done  <= 1'b1;
                r_frame_error <= (w_idx_next != '0);
            end
        end
    end

    assign tx_rd         = w_tx_load && tx_valid;
    assign spi_data_send = r_tx_shift[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
    assign rx_wr         = r_rx_wr;
    assign rx_data       = r_rx_data;
    assign word_cnt      = r_word_cnt;
    assign frame_done    = r_frame_done;
    assign frame_error   = r_frame_error;
    assign tx_underflow  = r_tx_underflow;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_spi_word_packer.sv
// Directed bench for spi_word_packer: frame-level model of rx words, tx byte stream and frame flags.
module tb_spi_word_packer;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        spi_ready;
    logic [7:0]  spi_data_receive;
    logic [7:0]  spi_data_send;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_rd;
    logic        rx_wr;
    logic [31:0] rx_data;
    logic [7:0]  word_cnt;
    logic        frame_done;
    logic        frame_error;
    logic        tx_underflow;
    logic        dbg_state;

    spi_word_packer dut (
        .clk              (clk),
        .rst              (rst),
        .cs               (cs),
        .spi_ready        (spi_ready),
        .spi_data_receive (spi_data_receive),
        .spi_data_send    (spi_data_send),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_rd            (tx_rd),
        .rx_wr            (rx_wr),
        .rx_data          (rx_data),
        .word_cnt         (word_cnt),
        .frame_done       (frame_done),
        .frame_error      (frame_error),
        .tx_underflow     (tx_underflow),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model state ----------------
    logic [31:0] txq[$];          // send buffer contents
    logic [31:0] frame_words[$];  // send buffer snapshot at frame start
    logic [31:0] exp_q[$];        // expected rx words
    logic [7:0]  sent_log[$];
    logic [31:0] acc;
    int          acc_n;
    int          frame_bytes;
    logic [7:0]  m_send;
    bit          m_send_valid;
    bit          rd_seen;
    int          rd_cnt;
    int          done_cnt;
    logic [31:0] last_rx;
    int          m_word_cnt;
    int          errors;
    int          checks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_send_byte(int k);
        int          w;
        logic [31:0] word;
        w = k / 4;
        if (w >= frame_words.size()) return 8'h00;
        word = frame_words[w];
        return 8'((word >> (8 * (3 - (k % 4)))) & 32'hFF);
    endfunction

    function automatic void update_tx();
        tx_valid = (txq.size() > 0);
        tx_data  = tx_valid ? txq[0] : 32'h0;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        acc = acc * 256 + {24'h0, b};
        acc_n++;
        frame_bytes++;
        if (acc_n == 4) begin
            exp_q.push_back(acc);
            acc   = 32'h0;
            acc_n = 0;
        end
    endfunction

    // ---------------- send buffer emulation ----------------
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (txq.size() > 0) void'(txq.pop_front());
            rd_seen = 1'b0;
            update_tx();
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            rd_seen = tx_rd;
            if (tx_rd) rd_cnt++;
            if (frame_done) done_cnt++;
            if (rx_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_wr_unexpected: got data %0h, no word expected", rx_data);
                end else begin
                    check("rx_data", {32'h0, rx_data}, {32'h0, exp_q.pop_front()});
                end
                last_rx = rx_data;
            end
            if (m_send_valid) check("spi_data_send", {56'h0, spi_data_send}, {56'h0, m_send});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic frame_begin();
        frame_words = txq;
        sent_log.delete();
        frame_bytes = 0;
        acc         = 32'h0;
        acc_n       = 0;
        rd_cnt      = 0;
        done_cnt    = 0;
        cs          = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("active_state", {63'h0, dbg_state}, 64'h1);
        m_send       = exp_send_byte(0);
        m_send_valid = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sent_log.push_back(spi_data_send);
        spi_data_receive = b;
        spi_ready        = 1'b1;
        @(posedge clk);
        #1;
        spi_ready = 1'b0;
        model_byte(b);
        m_send = exp_send_byte(frame_bytes);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic idle_byte(input logic [7:0] b);
        spi_data_receive = b;
        spi_ready        = 1'b1;
        @(posedge clk);
        #1;
        spi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frame_end();
        m_send_valid = 1'b0;
        cs           = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Last byte lands in the same cycle the synchronised cs_rise reaches the packer.
    task automatic frame_end_with_byte(input logic [7:0] b);
        m_send_valid = 1'b0;
        cs           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spi_data_receive = b;
        spi_ready        = 1'b1;
        @(posedge clk);
        #1;
        spi_ready = 1'b0;
        model_byte(b);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic frame_check(input string tag);
        int loads;
        int exp_rd;
        int exp_cnt;
        loads   = 1 + frame_bytes / 4;
        exp_rd  = (loads < frame_words.size()) ? loads : frame_words.size();
        exp_cnt = (frame_bytes / 4 > 255) ? 255 : frame_bytes / 4;
        m_word_cnt = exp_cnt;
        check({tag, "_frame_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_word_cnt"}, {56'h0, word_cnt}, 64'(exp_cnt));
        check({tag, "_frame_error"}, {63'h0, frame_error}, {63'h0, (frame_bytes % 4) != 0});
        check({tag, "_tx_underflow"}, {63'h0, tx_underflow}, {63'h0, loads > frame_words.size()});
        check({tag, "_tx_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
        check({tag, "_rx_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle_state"}, {63'h0, dbg_state}, 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_spi_data_send"}, {56'h0, spi_data_send}, 64'h0);
        check({tag, "_rx_data"}, {32'h0, rx_data}, 64'h0);
        check({tag, "_word_cnt"}, {56'h0, word_cnt}, 64'h0);
        check({tag, "_rx_wr"}, {63'h0, rx_wr}, 64'h0);
        check({tag, "_tx_rd"}, {63'h0, tx_rd}, 64'h0);
        check({tag, "_frame_done"}, {63'h0, frame_done}, 64'h0);
        check({tag, "_frame_error"}, {63'h0, frame_error}, 64'h0);
        check({tag, "_tx_underflow"}, {63'h0, tx_underflow}, 64'h0);
        check({tag, "_state"}, {63'h0, dbg_state}, 64'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        errors = 0; checks = 0;
        m_send_valid = 1'b0; rd_seen = 1'b0;
        acc = 32'h0; acc_n = 0; frame_bytes = 0;
        rd_cnt = 0; done_cnt = 0; last_rx = 32'h0; m_word_cnt = 0; m_send = 8'h0;
        rst = 1'b0; cs = 1'b1; spi_ready = 1'b0; spi_data_receive = 8'h0;
        txq.delete();
        update_tx();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Frame 1: one full word each way
        txq = '{32'h11223344, 32'h55667788};
        update_tx();
        frame_begin();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        frame_end();
        frame_check("f1");
        check("f1_rx_literal", {32'h0, last_rx}, 64'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] lit [4];
            lit = '{8'h11, 8'h22, 8'h33, 8'h44};
            check($sformatf("f1_send_literal%0d", i), {56'h0, sent_log[i]}, {56'h0, lit[i]});
        end

        // Bytes outside a frame are ignored
        idle_byte(8'h5A);
        idle_byte(8'hA5);
        check("idle_word_cnt", {56'h0, word_cnt}, 64'(m_word_cnt));

        // Frame 2: six bytes, partial word at the end
        txq = '{32'hA1B2C3D4};
        update_tx();
        frame_begin();
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        frame_end();
        frame_check("f2");
        check("f2_rx_literal", {32'h0, last_rx}, 64'h01020304);

        // Frame 3: send buffer runs dry at the second word boundary
        txq = '{32'hCAFE0001};
        update_tx();
        frame_begin();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h80 + i));
        frame_end();
        frame_check("f3");
        for (int i = 4; i < 8; i++) check($sformatf("f3_send_zero%0d", i), {56'h0, sent_log[i]}, 64'h0);
        repeat (5) @(posedge clk);
        #1;
        check("f3_underflow_held", {63'h0, tx_underflow}, 64'h1);

        // Frame 4: last byte coincides with cs_rise
        txq = '{32'h0BADC0DE, 32'h12345678};
        update_tx();
        frame_begin();
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        frame_end_with_byte(8'h40);
        frame_check("f4");
        check("f4_rx_literal", {32'h0, last_rx}, 64'h10203040);

        // Frame 5: reset after two bytes
        txq = '{32'hDDCCBBAA};
        update_tx();
        frame_begin();
        send_byte(8'h77); send_byte(8'h66);
        #2;
        rst = 1'b0;
        cs  = 1'b1;
        m_send_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        txq.delete();
        update_tx();
        exp_q.delete();
        rd_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_still_idle", {63'h0, dbg_state}, 64'h0);

        // Frame 6: clean word after reset, no residue
        txq = '{32'hCAFEBABE};
        update_tx();
        frame_begin();
        send_byte(8'h0F); send_byte(8'h1E); send_byte(8'h2D); send_byte(8'h3C);
        frame_end();
        frame_check("f6");
        check("f6_rx_literal", {32'h0, last_rx}, 64'h0F1E2D3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_word_packer.md
# spi_word_packer

Byte-to-word adapter between `spi_slave_driver` and the word-wide SPI buffers of the slave SPI processing unit.

- **Receive path:** packs consecutive received SPI bytes, MSB-first, into `DATA_WIDTH` words and pushes each complete word to the receive buffer.
- **Transmit path:** pops words from the send buffer and serialises them into bytes for the driver.
- **Framing:** tracks chip-select framing, counts words per frame and flags frames that end on a partial word.

## Interface

Parameters:
- `DATA_WIDTH`, 32 — word width; must be an integer multiple of `SPI_DATA_WIDTH`.
- `SPI_DATA_WIDTH`, 8 — SPI byte width.
- `CNT_WIDTH`, 8 — width of the per-frame word counter.

Ports (one clock; `rst` is asynchronous and active-low):
- `clk`  in  1 — system clock.
- `rst`  in  1 — asynchronous reset, active-low.
- `cs`  in  1 — SPI chip select, raw from pad; high = deselected.
- `spi_ready`  in  1 — one-cycle pulse from the driver per completed byte.
- `spi_data_receive`  in  `SPI_DATA_WIDTH` — byte just received; valid while `spi_ready` is high.
- `spi_data_send`  out  `SPI_DATA_WIDTH` — byte the driver shifts out next.
- `tx_valid`  in  1 — send buffer holds a word.
- `tx_data`  in  `DATA_WIDTH` — send buffer head word.
- `tx_rd`  out  1 — one-cycle pop of the send buffer head.
- `rx_wr`  out  1 — one-cycle push to the receive buffer.
- `rx_data`  out  `DATA_WIDTH` — assembled word; valid while `rx_wr` is high.
- `word_cnt`  out  `CNT_WIDTH` — complete words received in the current or last frame.
- `frame_done`  out  1 — one-cycle pulse at the end of a frame.
- `frame_error`  out  1 — the last frame ended on a partial word.
- `tx_underflow`  out  1 — a word boundary was reached with `tx_valid` low during the current or last frame.

## Operation

- `BYTES = DATA_WIDTH / SPI_DATA_WIDTH`; a byte index `idx` runs 0..`BYTES`-1.
- `cs` passes through a 2-flop synchroniser and an edge detector; `cs_fall`/`cs_rise` are single-cycle internal strobes.
- FSM has two states:
  - IDLE: reset state, `cs` high. On `cs_fall` → ACTIVE.
  - ACTIVE: on `cs_rise` → IDLE.
- On entering ACTIVE:
  - `idx` ← 0, `word_cnt` ← 0; `frame_error` and `tx_underflow` are cleared.
  - The tx shift register loads `tx_data`. If `tx_valid` is high, `tx_rd` pulses; otherwise the register loads 0 and `tx_underflow` is set.
- Receive, on `spi_ready` in ACTIVE:
  - `rx_shift` ← {`rx_shift[DATA_WIDTH-SPI_DATA_WIDTH-1:0]`, `spi_data_receive`}; `idx` increments.
  - At `idx` = `BYTES`-1: `idx` ← 0, `rx_wr` pulses next cycle with the full word, and `word_cnt` increments, saturating at all-ones.
- Transmit, on the same `spi_ready`:
  - The tx shift register shifts left by `SPI_DATA_WIDTH`.
  - At a word boundary it reloads from `tx_data`, with `tx_rd` pulsed when `tx_valid` is high; otherwise it loads 0 and sets `tx_underflow`.
  - `spi_data_send` is always the top `SPI_DATA_WIDTH` bits of the tx shift register.
- `spi_ready` while in IDLE is ignored.
- End of frame (`cs_rise`):
  - `frame_done` pulses.
  - `frame_error` ← (`idx` ≠ 0); the partial rx word is discarded with no `rx_wr`.
  - A partially sent tx word is dropped; it is not re-pushed.
- `spi_ready` and `cs_rise` in the same cycle: the byte is processed first. The end-of-frame check uses the updated `idx`, and a word completed by that byte is still written.
- A `cs_fall` one cycle after `cs_rise` is legal; the new frame starts normally.

## Timing

- Reset: all outputs 0.
  - `spi_data_send` = 0, `rx_data` = 0, `word_cnt` = 0; all flags and strobes low.
  - FSM in IDLE; synchroniser flops reset to 1 (deselected).
- `cs` to `cs_fall`/`cs_rise` latency: 3 `clk` (2 synchroniser stages + edge register).
- `spi_ready` → `rx_wr`: 1 cycle after the cycle `spi_ready` is sampled.
- `spi_ready` → updated `spi_data_send`: 1 cycle. The driver must not start the next byte's first `sclk` edge earlier than 2 `clk` after `spi_ready`.
- `tx_rd` is asserted in the same cycle the word is loaded. `tx_data` must present the new head one cycle after `tx_rd`.
- The first byte of a frame is valid on `spi_data_send` 4 `clk` after the `cs` fall at the pad.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The next frame begins only on a fresh `cs_fall` after release.

## Structure

- Add `cs` polarity constants to `parameters.vh`: `CS_ACTIVE = 0`, `CS_IDLE = 1`.
- FSM encodings, `BYTES` and index width are local parameters.
- One sub-module: `spi_cs_sync` (2-flop synchroniser plus rise/fall strobes, reset-to-deselected).
- The rest is flat: rx shift register, tx shift register, index counter, word counter and flags.

## Test plan

- One 4-byte frame, bytes 0xDE 0xAD 0xBE 0xEF → one `rx_wr` with `rx_data` = 0xDEADBEEF; `word_cnt` = 1; `frame_error` = 0; `frame_done` pulses once.
- `tx_data` = 0x11223344 with `tx_valid` high at `cs` fall, then 4 byte strobes → `spi_data_send` sequence 0x11, 0x22, 0x33, 0x44; one `tx_rd` at frame start and one at the word boundary.
- 6-byte frame → one `rx_wr`; `frame_error` = 1 after `cs` rise; `word_cnt` = 1; no second `rx_wr`.
- `tx_valid` low at the second word boundary → bytes 5–8 on `spi_data_send` are 0x00; `tx_underflow` = 1 until the next `cs` fall.
- `spi_ready` in the same cycle as `cs_rise`, completing byte 4 → `rx_wr` still issued; `frame_error` = 0.
- `rst` low after byte 2 of a frame → all outputs 0 immediately. After release, a new 4-byte frame yields a correct word with no residue from the old bytes.
